// File: rtl/dca_matrix_lsu_pkg.sv
// Shared matrix-LSU types and element-size/beat-count helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dca_matrix_lsu_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } row_ser_state_e;

    function automatic int axi_strb_bits(input int bw_axi_data);
        return bw_axi_data / 8;
    endfunction

    // Encodings above 5 fall back to 32-bit elements.
    function automatic int elem_bits(input logic [2:0] lsa_p3);
        return (lsa_p3 > 3'd5) ? 32 : (1 << lsa_p3);
    endfunction

    function automatic int row_num_beats(input logic [2:0] lsa_p3, input int num_col,
                                         input int bw_axi_data);
        int row_bytes;
        int beats;
        row_bytes = (num_col * elem_bits(lsa_p3) + 7) / 8;
        if (row_bytes < 1) row_bytes = 1;
        beats = (row_bytes + axi_strb_bits(bw_axi_data) - 1) / axi_strb_bits(bw_axi_data);
        if (beats < 1) beats = 1;
        return beats;
    endfunction

endpackage

// File: rtl/dca_matrix_row_wdata_serializer_if.sv
// Row-in / AXI-W-out bundle for the row write-data serializer.
// Latency: n/a (wires only).
// Backpressure: row_valid/row_ready on input side, wvalid/wready on output side.
interface dca_matrix_row_wdata_serializer_if #(
    parameter int BW_AXI_DATA    = 32,
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_ROW_BUFFER  = 32 * MATRIX_NUM_COL,
    parameter int BW_TXN_INFO    = 16
);
    logic                      row_valid;
    logic                      row_ready;
    logic [BW_ROW_BUFFER-1:0]  row_data;
    logic [2:0]                row_elem_lsa_p3;
    logic [MATRIX_NUM_COL-1:0] row_col_mask;
    logic [BW_TXN_INFO-1:0]    row_txn_info;

    logic                      wvalid;
    logic                      wready;
    logic [BW_AXI_DATA-1:0]    wdata;
    logic [BW_AXI_DATA/8-1:0]  wstrb;
    logic                      wlast;
    logic [BW_TXN_INFO-1:0]    wtxn_info;

    modport slave (
        input  row_valid, row_data, row_elem_lsa_p3, row_col_mask, row_txn_info, wready,
        output row_ready, wvalid, wdata, wstrb, wlast, wtxn_info
    );

    modport master (
        output row_valid, row_data, row_elem_lsa_p3, row_col_mask, row_txn_info, wready,
        input  row_ready, wvalid, wdata, wstrb, wlast, wtxn_info
    );
endinterface

// File: rtl/dca_row_strb_gen.sv
// Column mask + element size -> per-byte write strobes for a packed row.
// Latency: combinational.
// Backpressure: none.
module dca_row_strb_gen
    import dca_matrix_lsu_pkg::*;
#(
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_ROW_BUFFER  = 32 * MATRIX_NUM_COL
) (
    input  logic [2:0]                 lsa_p3,
    input  logic [MATRIX_NUM_COL-1:0]  col_mask,
    output logic [BW_ROW_BUFFER/8-1:0] row_strb
);
    int ebits;
    assign ebits = elem_bits(lsa_p3);

    // A byte is written if any enabled column's bit range overlaps it; bytes
    // past the packed row are never covered by a column, so stay clear.
    always_comb begin
        row_strb = '0;
        for (int k = 0; k < BW_ROW_BUFFER / 8; k++) begin
            for (int i = 0; i < MATRIX_NUM_COL; i++) begin
                if (col_mask[i] && (ebits * i < 8 * k + 8) && (ebits * (i + 1) > 8 * k))
                    row_strb[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dca_matrix_row_wdata_serializer.sv
// Splits one packed row per handshake into AXI W beats with wstrb/wlast; optional DCA_ROW_WDATA_STALL_COUNT_EN stall counter.
// Latency: row accepted at edge N shows beat 0 in cycle N+1; back-to-back rows without bubble.
// Backpressure: outputs held while wvalid & !wready; row_ready only in IDLE or on the last-beat handshake.
module dca_matrix_row_wdata_serializer
    import dca_matrix_lsu_pkg::*;
#(
    parameter int BW_AXI_DATA    = 32,
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_ROW_BUFFER  = 32 * MATRIX_NUM_COL,
    parameter int BW_TXN_INFO    = 16
) (
    input  logic        clk,
    input  logic        rstnn,
    input  logic        clear,
    dca_matrix_row_wdata_serializer_if.slave bus,
    output logic [31:0] stall_count
);
    localparam int BW_AXI_STRB = axi_strb_bits(BW_AXI_DATA);
    localparam int BW_ROW_STRB = BW_ROW_BUFFER / 8;
    localparam int MAX_BEATS   = (BW_ROW_BUFFER + BW_AXI_DATA - 1) / BW_AXI_DATA;
    localparam int BEAT_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int PAD_DATA    = MAX_BEATS * BW_AXI_DATA;
    localparam int PAD_STRB    = MAX_BEATS * BW_AXI_STRB;

    row_ser_state_e          state_q, state_d;
    logic [PAD_DATA-1:0]     row_data_q, row_data_d, row_data_pad;
    logic [PAD_STRB-1:0]     row_strb_q, row_strb_d, row_strb_pad;
    logic [BW_ROW_STRB-1:0]  row_strb_new;
    logic [BEAT_W-1:0]       beat_idx_q, beat_idx_d, last_idx_q, last_idx_d, beat_nxt;
    logic                    wvalid_q, wvalid_d, wlast_q, wlast_d;
    logic [BW_AXI_DATA-1:0]  wdata_q, wdata_d;
    logic [BW_AXI_STRB-1:0]  wstrb_q, wstrb_d;
    logic [BW_TXN_INFO-1:0]  wtxn_q, wtxn_d;
    logic                    row_ready, w_fire, row_accept;

    dca_row_strb_gen #(
        .MATRIX_NUM_COL (MATRIX_NUM_COL),
        .BW_ROW_BUFFER  (BW_ROW_BUFFER)
    ) u_strb_gen (
        .lsa_p3   (bus.row_elem_lsa_p3),
        .col_mask (bus.row_col_mask),
        .row_strb (row_strb_new)
    );

    // Gating with clear keeps the handshake honest: a row offered alongside
    // clear is never seen as accepted.
    assign row_ready = !clear && ((state_q == ST_IDLE) || (wlast_q && bus.wready));

    always_comb begin
        row_data_pad = '0;
        row_data_pad[BW_ROW_BUFFER-1:0] = bus.row_data;
        row_strb_pad = '0;
        row_strb_pad[BW_ROW_STRB-1:0] = row_strb_new;
        w_fire     = wvalid_q && bus.wready;
        row_accept = bus.row_valid && row_ready;
        beat_nxt   = beat_idx_q + BEAT_W'(1);

        state_d    = state_q;
        row_data_d = row_data_q;
        row_strb_d = row_strb_q;
        beat_idx_d = beat_idx_q;
        last_idx_d = last_idx_q;
        wvalid_d   = wvalid_q;
        wlast_d    = wlast_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wtxn_d     = wtxn_q;

        if (clear) begin
            state_d    = ST_IDLE;
            beat_idx_d = '0;
            wvalid_d   = 1'b0;
            wlast_d    = 1'b0;
        end else if (row_accept) begin
            state_d    = ST_SEND;
            row_data_d = row_data_pad;
            row_strb_d = row_strb_pad;
            last_idx_d = BEAT_W'(row_num_beats(bus.row_elem_lsa_p3, MATRIX_NUM_COL, BW_AXI_DATA) - 1);
            beat_idx_d = '0;
            wvalid_d   = 1'b1;
            wdata_d    = row_data_pad[BW_AXI_DATA-1:0];
            wstrb_d    = row_strb_pad[BW_AXI_STRB-1:0];
            wlast_d    = (last_idx_d == '0);
            wtxn_d     = bus.row_txn_info;
        end else if (w_fire) begin
            if (wlast_q) begin
                state_d  = ST_IDLE;
                wvalid_d = 1'b0;
                wlast_d  = 1'b0;
            end else begin
                beat_idx_d = beat_nxt;
                wdata_d    = row_data_q[int'(beat_nxt) * BW_AXI_DATA +: BW_AXI_DATA];
                wstrb_d    = row_strb_q[int'(beat_nxt) * BW_AXI_STRB +: BW_AXI_STRB];
                wlast_d    = (beat_nxt == last_idx_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= ST_IDLE;
            row_data_q <= '0;
            row_strb_q <= '0;
            beat_idx_q <= '0;
            last_idx_q <= '0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wtxn_q     <= '0;
        end else begin
            state_q    <= state_d;
            row_data_q <= row_data_d;
            row_strb_q <= row_strb_d;
            beat_idx_q <= beat_idx_d;
            last_idx_q <= last_idx_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wtxn_q     <= wtxn_d;
        end
    end

    assign bus.row_ready = row_ready;
    assign bus.wvalid    = wvalid_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.wlast     = wlast_q;
    assign bus.wtxn_info = wtxn_q;

`ifdef DCA_ROW_WDATA_STALL_COUNT_EN
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (clear)
            stall_count_d = '0;
        else if (wvalid_q && !bus.wready && (stall_count_q != '1))
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) stall_count_q <= '0;
        else        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;
`else
    assign stall_count = '0;
`endif
endmodule

// File: doc/dca_matrix_row_wdata_serializer.md
Name: dca_matrix_row_wdata_serializer

Overview:
- Store-path stage directly downstream of the matrix LSU element-width converter.
- Accepts one packed memory row buffer per handshake, with its element size, column-enable mask and transaction info, and splits it into AXI write-data beats.
- Generates wstrb from the column mask and asserts wlast on the final beat of each row.
- Feeds the LSU AXI W channel; AW is issued elsewhere and uses the same beat count.

Parameters:
- BW_AXI_DATA, 32, AXI write-data width in bits; power of two, 32..512.
- MATRIX_NUM_COL, 4, elements per row.
- BW_ROW_BUFFER, 32*MATRIX_NUM_COL, packed row width (maximum element 32 bits).
- BW_TXN_INFO, 16, opaque transaction tag, carried unchanged.

Ports:
- clk  input  1  clock.
- rstnn  input  1  asynchronous active-low reset.
- clear  input  1  synchronous abort; returns the block to IDLE.
- row_valid  input  1  a packed row is offered.
- row_ready  output  1  the block accepts the offered row.
- row_data  input  BW_ROW_BUFFER  element i is at [ebits*i +: ebits].
- row_elem_lsa_p3  input  3  log2 of element bits: 0=1b, 1=2b, 2=4b, 3=8b, 4=16b, 5=32b. Values 6 and 7 are treated as 5.
- row_col_mask  input  MATRIX_NUM_COL  column i is enabled for write.
- row_txn_info  input  BW_TXN_INFO  transaction tag.
- wvalid  output  1  AXI W valid.
- wready  input  1  AXI W ready.
- wdata  output  BW_AXI_DATA  write data.
- wstrb  output  BW_AXI_DATA/8  byte strobes.
- wlast  output  1  final beat of the row.
- wtxn_info  output  BW_TXN_INFO  tag of the row currently being sent.
- stall_count  output  32  W-channel backpressure cycles (see Optional Feature).

Behaviour:
- Reset values:
  - state = IDLE.
  - wvalid, wlast = 0.
  - wdata, wstrb, wtxn_info = 0.
  - row_ready = 1.
  - stall_count = 0.
- Derived values per row:
  - ebits = 1 << min(lsa_p3, 5).
  - row_bytes = ceil(MATRIX_NUM_COL * ebits / 8), minimum 1.
  - num_beats = ceil(row_bytes / (BW_AXI_DATA/8)), minimum 1.
- Byte strobes:
  - Byte k of the row is strobed if any enabled column overlaps it.
  - For sub-byte elements, the whole byte is written when any element in it is enabled. Software owns partial-byte safety.
  - Bytes beyond row_bytes are never strobed.
- FSM states: IDLE and SEND.
  - IDLE: row_ready = 1. On row_valid, register row data, strobes, num_beats and tag, set beat_idx = 0, and go to SEND.
  - SEND: wvalid = 1, wdata = row slice [beat_idx*BW_AXI_DATA +: BW_AXI_DATA], wstrb = matching strobe slice, wlast = (beat_idx == num_beats-1).
  - On wvalid & wready with wlast = 0: beat_idx increments.
  - On wvalid & wready with wlast = 1: return to IDLE, unless a new row is accepted in the same cycle (see back-to-back rule).
- Latency: a row accepted at edge N presents beat 0 in cycle N+1.
- Back-to-back rows:
  - row_ready = IDLE | (SEND & wlast & wready).
  - A row accepted on the last-beat handshake loads directly and stays in SEND. There is no bubble.
- Stability: while wvalid & !wready, wdata, wstrb, wlast and wtxn_info are held unchanged.
- An all-zero row_col_mask still emits num_beats beats with wstrb = 0, keeping the W count consistent with AW.
- clear:
  - Highest priority.
  - Next cycle: state = IDLE, wvalid = 0, beat_idx = 0, row_ready = 1.
  - Any row offered in the same cycle as clear is not accepted.
- Asynchronous reset mid-row drops the row immediately with no further beats.

Optional Feature:
- Macro: DCA_ROW_WDATA_STALL_COUNT_EN.
- Enabled: stall_count increments each cycle wvalid & !wready, saturating at 2^32-1. It is reset by rstnn and by clear.
- Disabled: stall_count is tied to 0 and no counter logic is instantiated.

Decomposition:
- Shared package (dca_matrix_lsu_pkg):
  - element-size decode function (lsa_p3 to ebits with clamp at 5);
  - BW_AXI_STRB = BW_AXI_DATA/8;
  - beat-count function;
  - state encoding constants.
- One natural sub-module: dca_row_strb_gen.
  - Combinational: column mask plus lsa_p3 produce the row byte-strobe vector of BW_ROW_BUFFER/8 bits.
  - Verified standalone.

Test Plan:
(Defaults: BW_AXI_DATA = 32, MATRIX_NUM_COL = 4.)
1. lsa_p3 = 3, row_data[31:0] = 0x44332211, mask 4'b1111, wready = 1 -> one beat next cycle with wdata 0x44332211, wstrb 4'hF, wlast = 1; then row_ready = 1.
2. lsa_p3 = 5, words 0xA0,0xA1,0xA2,0xA3, mask 4'b1011 -> 4 beats, wstrb F,F,0,F; wdata A0..A3; wlast only on beat 3; tag constant throughout.
3. lsa_p3 = 4, mask 4'b0110, wready low for 3 cycles on beat 0 -> outputs frozen during the stall; beats carry wstrb 4'hC then 4'h3. With the macro enabled, stall_count = 3.
4. Two rows, second row_valid asserted during the last beat with wready = 1 -> row_ready = 1 that cycle and the second row's beat 0 follows in the next cycle with no gap.
5. lsa_p3 = 1, mask 4'b0001, row_data[7:0] = 0xE4 -> one beat, wdata[7:0] = 0xE4, wstrb 4'b0001, wlast = 1.
6. clear asserted on beat 1 of a 4-beat row, with row_valid also high -> wvalid = 0 the next cycle, the offered row is not accepted, state is IDLE, and stall_count = 0.
